matmul_param: RTL

//  Parametrised fixed-point matrix multiplier: C = A x B, or A x B^T when trans_b=1.

---
 rtl/matmul_param.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_param.sv
// Sequential fixed-point matrix multiplier (C = A x B or A x B^T), one MAC per cycle.
// Optional saturation of results is enabled by defining MATMUL_SAT_EN.
module matmul_param #(
   parameter int W      = 32,
   parameter int FRAC   = 12,
   parameter int MAXDIM = 6,
   parameter int ACCW   = 2*W+4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         trans_b,
   input  logic [7:0]                   rows_a,
   input  logic [7:0]                   cols_a,
   input  logic [7:0]                   cols_b,
   input  logic [MAXDIM*MAXDIM*W-1:0]   a_in,
   input  logic [MAXDIM*MAXDIM*W-1:0]   b_in,
   output logic [MAXDIM*MAXDIM*W-1:0]   c_out,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         sat
);

   localparam int NW = MAXDIM*MAXDIM*W;
   localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (FRAC-1);

   // LOAD sits between IDLE and MAC so the dimension check sees latched dims
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_FIN} state_t;

   state_t                  state_q, state_d;
   logic [NW-1:0]           a_q, a_d, b_q, b_d, c_q, c_d, c_out_q, c_out_d;
   logic [7:0]              ra_q, ra_d, ca_q, ca_d, cb_q, cb_d;
   logic [7:0]              i_q, i_d, j_q, j_d, k_q, k_d;
   logic                    tb_q, tb_d, errf_q, errf_d;
   logic signed [ACCW-1:0]  acc_q, acc_d;
   logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [15:0]             idx_a, idx_b, idx_c;
   logic signed [W-1:0]     a_el, b_el;
   logic signed [2*W-1:0]   prod;
   logic signed [ACCW-1:0]  rnd_sum, rnd;
   logic [W-1:0]            r;
   logic                    dims_bad;

`ifdef MATMUL_SAT_EN
   localparam logic signed [ACCW-1:0] MAXV = (ACCW'(1) << (W-1)) - ACCW'(1);
   localparam logic signed [ACCW-1:0] MINV = -MAXV - ACCW'(1);
   logic sat_q, sat_d, clip;
`else
   logic unused_rnd;
`endif

   always_comb begin
      idx_a   = 16'(i_q) * 16'(ca_q) + 16'(k_q);
      idx_b   = tb_q ? (16'(j_q) * 16'(ca_q) + 16'(k_q))
                     : (16'(k_q) * 16'(cb_q) + 16'(j_q));
      idx_c   = 16'(i_q) * 16'(cb_q) + 16'(j_q);
      a_el    = a_q[32'(idx_a)*W +: W];
      b_el    = b_q[32'(idx_b)*W +: W];
      prod    = a_el * b_el;
      rnd_sum = acc_q + HALF;
      rnd     = rnd_sum >>> FRAC;
`ifdef MATMUL_SAT_EN
      clip = 1'b0;
      if (rnd > MAXV) begin
         r    = MAXV[W-1:0];
         clip = 1'b1;
      end else if (rnd < MINV) begin
         r    = MINV[W-1:0];
         clip = 1'b1;
      end else begin
         r = rnd[W-1:0];
      end
`else
      r = rnd[W-1:0];
`endif
      dims_bad = (ra_q == 8'd0) || (ra_q > 8'(MAXDIM)) ||
                 (ca_q == 8'd0) || (ca_q > 8'(MAXDIM)) ||
                 (cb_q == 8'd0) || (cb_q > 8'(MAXDIM));
   end

`ifndef MATMUL_SAT_EN
   assign unused_rnd = ^{rnd[ACCW-1:W]};
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      c_out_d = c_out_q;
      ra_d    = ra_q;
      ca_d    = ca_q;
      cb_d    = cb_q;
      tb_d    = tb_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      acc_d   = acc_q;
      errf_d  = errf_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
`ifdef MATMUL_SAT_EN
      sat_d   = sat_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               ra_d    = rows_a;
               ca_d    = cols_a;
               cb_d    = cols_b;
               tb_d    = trans_b;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (dims_bad) begin
               errf_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               errf_d  = 1'b0;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               c_d     = '0;
`ifdef MATMUL_SAT_EN
               sat_d   = 1'b0;
`endif
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + ACCW'(prod);
            if (k_q == ca_q - 8'd1) state_d = S_WB;
            else                    k_d     = k_q + 8'd1;
         end
         S_WB: begin
            c_d[32'(idx_c)*W +: W] = r;
`ifdef MATMUL_SAT_EN
            if (clip) sat_d = 1'b1;
`endif
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
            if (j_q == cb_q - 8'd1) begin
               j_d = '0;
               if (i_q == ra_q - 8'd1) state_d = S_FIN;
               else                    i_d     = i_q + 8'd1;
            end else begin
               j_d = j_q + 8'd1;
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            err_d   = errf_q;
            if (!errf_q) c_out_d = c_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // busy spans the run including FIN, but never an error-only pass
      busy_d = (state_d == S_MAC) || (state_d == S_WB) ||
               (state_q == S_WB && state_d == S_FIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         c_out_q <= '0;
         ra_q    <= '0;
         ca_q    <= '0;
         cb_q    <= '0;
         tb_q    <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         errf_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MATMUL_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         c_out_q <= c_out_d;
         ra_q    <= ra_d;
         ca_q    <= ca_d;
         cb_q    <= cb_d;
         tb_q    <= tb_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         errf_q  <= errf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef MATMUL_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign c_out = c_out_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
`ifdef MATMUL_SAT_EN
   assign sat   = sat_q;
`else
   assign sat   = 1'b0;
`endif

endmodule
